// File: rtl/keccak_unpadder_if.sv
// Stream bundle for keccak_unpadder: padded words in, message words out, plus the pad error pulse.
// The master side feeds padded words and accepts message words; the slave side is the unpadder.
interface keccak_unpadder_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic [1:0]  out_byte_num;
    logic        out_ready;
    logic        pad_err;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_byte_num, pad_err
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_byte_num, pad_err
    );
endinterface

// File: rtl/keccak_unpadder.sv
// SHA-3 unpadder: buffers one rate block, strips the 0x06..0x80 pad from the final block and
// re-emits the message as 32-bit words with a last-word valid byte count.
module keccak_unpadder #(
    parameter int unsigned RATE_WORDS = 18,
    parameter logic [7:0]  PAD_BYTE   = 8'h06
) (
    input logic              clk,
    input logic              rst_n,
    keccak_unpadder_if.slave bus
);
    localparam int unsigned NB = 4 * RATE_WORDS;
    localparam int unsigned IW = $clog2(RATE_WORDS + 1);
    localparam int unsigned AW = $clog2(RATE_WORDS);
    localparam int unsigned BW = $clog2(NB);
    localparam int unsigned PW = $clog2(NB + 1);
    localparam logic [IW-1:0] LastIdx  = IW'(RATE_WORDS - 1);
    localparam logic [BW-1:0] LastByte = BW'(NB - 1);

    typedef enum logic [1:0] {StFill, StScan, StDrainFull, StDrainLast} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] widx_q, widx_d;
    logic [BW-1:0] bptr_q, bptr_d;
    logic          seen80_q, seen80_d;
    logic [PW-1:0] p_q, p_d;
    logic [31:0]   out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [1:0]    out_byte_num_q, out_byte_num_d;
    logic          pad_err_q, pad_err_d;
    logic [31:0]   buf_q [RATE_WORDS];

    logic          in_ready;
    logic          in_fire;
    logic          load_en;
    logic [31:0]   scan_word;
    logic [7:0]    scan_byte;
    logic [IW-1:0] last_widx;
    logic [IW-1:0] n_emit;
    logic [1:0]    p_rem;
    logic [31:0]   last_mask;
    logic [31:0]   drain_word;

    assign in_ready  = rst_n && (state_q == StFill);
    assign in_fire   = bus.in_valid && in_ready;
    assign load_en   = !out_valid_q || bus.out_ready;
    assign scan_word = buf_q[bptr_q[BW-1:2]];
    assign last_widx = IW'(p_q >> 2);
    assign p_rem     = p_q[1:0];
    assign n_emit    = (state_q == StDrainLast) ? last_widx + IW'(1) : IW'(RATE_WORDS);
    assign drain_word = buf_q[widx_q[AW-1:0]];

    // Byte 0 of each word sits in the most significant lane.
    always_comb begin
        scan_byte = 8'h00;
        last_mask = 32'h0000_0000;
        case (bptr_q[1:0])
            2'd0:    scan_byte = scan_word[31:24];
            2'd1:    scan_byte = scan_word[23:16];
            2'd2:    scan_byte = scan_word[15:8];
            default: scan_byte = scan_word[7:0];
        endcase
        case (p_rem)
            2'd0:    last_mask = 32'h0000_0000;
            2'd1:    last_mask = 32'hFF00_0000;
            2'd2:    last_mask = 32'hFFFF_0000;
            default: last_mask = 32'hFFFF_FF00;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        widx_d         = widx_q;
        bptr_d         = bptr_q;
        seen80_d       = seen80_q;
        p_d            = p_q;
        out_data_d     = out_data_q;
        out_valid_d    = out_valid_q;
        out_last_d     = out_last_q;
        out_byte_num_d = out_byte_num_q;
        pad_err_d      = 1'b0;

        unique case (state_q)
            StFill: begin
                if (in_fire) begin
                    if (widx_q == LastIdx) begin
                        widx_d   = '0;
                        bptr_d   = LastByte;
                        seen80_d = 1'b0;
                        state_d  = bus.in_last ? StScan : StDrainFull;
                    end else if (bus.in_last) begin
                        pad_err_d = 1'b1;
                        widx_d    = '0;
                    end else begin
                        widx_d = widx_q + IW'(1);
                    end
                end
            end
            StScan: begin
                // Walk backward from the final byte: 0x80, zeros, then the domain byte.
                if (!seen80_q) begin
                    if (scan_byte == (PAD_BYTE | 8'h80)) begin
                        p_d     = PW'(NB - 1);
                        widx_d  = '0;
                        state_d = StDrainLast;
                    end else if (scan_byte == 8'h80) begin
                        seen80_d = 1'b1;
                        bptr_d   = bptr_q - BW'(1);
                    end else begin
                        pad_err_d = 1'b1;
                        state_d   = StFill;
                    end
                end else if (scan_byte == PAD_BYTE) begin
                    p_d     = PW'(bptr_q);
                    widx_d  = '0;
                    state_d = StDrainLast;
                end else if (scan_byte == 8'h00 && bptr_q != '0) begin
                    bptr_d = bptr_q - BW'(1);
                end else begin
                    pad_err_d = 1'b1;
                    state_d   = StFill;
                end
            end
            StDrainFull, StDrainLast: begin
                if (load_en) begin
                    if (widx_q < n_emit) begin
                        out_valid_d = 1'b1;
                        widx_d      = widx_q + IW'(1);
                        if (state_q == StDrainLast && widx_q == last_widx) begin
                            out_data_d     = drain_word & last_mask;
                            out_last_d     = 1'b1;
                            out_byte_num_d = p_rem;
                        end else begin
                            out_data_d     = drain_word;
                            out_last_d     = 1'b0;
                            out_byte_num_d = 2'd0;
                        end
                    end else begin
                        out_valid_d    = 1'b0;
                        out_data_d     = 32'h0000_0000;
                        out_last_d     = 1'b0;
                        out_byte_num_d = 2'd0;
                        widx_d         = '0;
                        state_d        = StFill;
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StFill;
            widx_q         <= '0;
            bptr_q         <= '0;
            seen80_q       <= 1'b0;
            p_q            <= '0;
            out_data_q     <= 32'h0000_0000;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            out_byte_num_q <= 2'd0;
            pad_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            widx_q         <= widx_d;
            bptr_q         <= bptr_d;
            seen80_q       <= seen80_d;
            p_q            <= p_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            out_last_q     <= out_last_d;
            out_byte_num_q <= out_byte_num_d;
            pad_err_q      <= pad_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            buf_q[widx_q[AW-1:0]] <= bus.in_data;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_data     = out_data_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_last     = out_last_q;
    assign bus.out_byte_num = out_byte_num_q;
    assign bus.pad_err      = pad_err_q;
endmodule

// File: tb/tb_keccak_unpadder.sv
// Directed bench for keccak_unpadder: hand-built padded blocks, expected message words,
// pad error cases, output stalls and a reset in the middle of a drain.
module tb_keccak_unpadder;
    localparam int RW = 18;
    localparam int NB = 4 * RW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keccak_unpadder_if bus();

    keccak_unpadder #(
        .RATE_WORDS (RW),
        .PAD_BYTE   (8'h06)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] blk [RW];
    logic [31:0] exp_d [32];
    logic        exp_l [32];
    logic [1:0]  exp_b [32];
    int          exp_n = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, got, want);
    endtask

    task automatic clear_blk();
        for (int i = 0; i < RW; i++) blk[i] = 32'h0;
    endtask

    task automatic pattern_blk();
        for (int i = 0; i < RW; i++) blk[i] = 32'h01020304 + 32'(i) * 32'h04040404;
    endtask

    task automatic push_exp(input logic [31:0] d, input logic l, input logic [1:0] b);
        exp_d[exp_n] = d;
        exp_l[exp_n] = l;
        exp_b[exp_n] = b;
        exp_n++;
    endtask

    task automatic send(input int n, input bit last);
        int k;
        for (int i = 0; i < n; i++) begin
            k = 0;
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = blk[i];
            bus.in_last  = last && (i == n - 1);
            while (!bus.in_ready && k < 200) begin
                @(negedge clk);
                k++;
            end
            if (k >= 200) check("in_ready_timeout", 32'd0, 32'd1);
            @(posedge clk);
        end
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic collect(input bit stall);
        int got, cyc;
        bit hold;
        logic [31:0] hd;
        logic hl;
        logic [1:0] hb;
        got = 0;
        cyc = 0;
        hold = 1'b0;
        hd = '0;
        hl = 1'b0;
        hb = '0;
        while (got < exp_n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hold) begin
                check("stall_valid", 32'(bus.out_valid), 32'd1);
                check("stall_data", bus.out_data, hd);
                check("stall_last", 32'(bus.out_last), 32'(hl));
                check("stall_bnum", 32'(bus.out_byte_num), 32'(hb));
            end
            hold = 1'b0;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    check($sformatf("data%0d", got), bus.out_data, exp_d[got]);
                    check($sformatf("last%0d", got), 32'(bus.out_last), 32'(exp_l[got]));
                    check($sformatf("bnum%0d", got), 32'(bus.out_byte_num), 32'(exp_b[got]));
                    got++;
                end else begin
                    hold = 1'b1;
                    hd = bus.out_data;
                    hl = bus.out_last;
                    hb = bus.out_byte_num;
                end
            end
        end
        check("word_count", 32'(got), 32'(exp_n));
        @(negedge clk);
        bus.out_ready = 1'b1;
        check("idle_valid", 32'(bus.out_valid), 32'd0);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);
        exp_n = 0;
    endtask

    task automatic expect_err(input string tag);
        int k;
        bit seen, bad_valid;
        k = 0;
        seen = 1'b0;
        bad_valid = 1'b0;
        while (!seen && k < NB + 10) begin
            @(negedge clk);
            k++;
            if (bus.out_valid) bad_valid = 1'b1;
            if (bus.pad_err) seen = 1'b1;
        end
        check({tag, "_pad_err"}, 32'(seen), 32'd1);
        check({tag, "_no_valid"}, 32'(bad_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(bus.pad_err), 32'd0);
    endtask

    task automatic three_byte_block();
        clear_blk();
        blk[0] = 32'h11223306;
        blk[RW-1] = 32'h00000080;
        send(RW, 1'b1);
        push_exp(32'h11223300, 1'b1, 2'd3);
        collect(1'b0);
    endtask

    initial begin
        int k;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.in_data = 32'h0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_out_bnum", 32'(bus.out_byte_num), 32'd0);
        check("rst_pad_err", 32'(bus.pad_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        three_byte_block();

        // Empty message
        clear_blk();
        blk[0] = 32'h06000000;
        blk[RW-1] = 32'h00000080;
        send(RW, 1'b1);
        push_exp(32'h00000000, 1'b1, 2'd0);
        collect(1'b0);

        // Six-byte message spanning two output words
        clear_blk();
        blk[0] = 32'hDEADBEEF;
        blk[1] = 32'h55660600;
        blk[RW-1] = 32'h00000080;
        send(RW, 1'b1);
        push_exp(32'hDEADBEEF, 1'b0, 2'd0);
        push_exp(32'h55660000, 1'b1, 2'd2);
        collect(1'b0);

        // 71 bytes with the combined 0x86 pad byte, random output stalls
        pattern_blk();
        blk[RW-1] = 32'hC1C2C386;
        send(RW, 1'b1);
        for (int i = 0; i < RW - 1; i++) push_exp(32'h01020304 + 32'(i) * 32'h04040404, 1'b0, 2'd0);
        push_exp(32'hC1C2C300, 1'b1, 2'd3);
        collect(1'b1);

        // 72 bytes: one full data block then a pad-only block
        pattern_blk();
        send(RW, 1'b0);
        for (int i = 0; i < RW; i++) push_exp(32'h01020304 + 32'(i) * 32'h04040404, 1'b0, 2'd0);
        collect(1'b1);
        clear_blk();
        blk[0] = 32'h06000000;
        blk[RW-1] = 32'h00000080;
        send(RW, 1'b1);
        push_exp(32'h00000000, 1'b1, 2'd0);
        collect(1'b0);

        // Error cases
        clear_blk();
        send(RW, 1'b1);
        expect_err("zero_tail");

        pattern_blk();
        send(6, 1'b1);
        expect_err("early_last");
        three_byte_block();

        clear_blk();
        blk[0] = 32'h06000000;
        blk[10] = 32'h00110000;
        blk[RW-1] = 32'h00000080;
        send(RW, 1'b1);
        expect_err("junk_in_pad");

        clear_blk();
        blk[RW-1] = 32'h00000080;
        send(RW, 1'b1);
        expect_err("no_pad_start");

        // Reset in the middle of a drain
        pattern_blk();
        blk[RW-1] = 32'hC1C2C386;
        send(RW, 1'b1);
        k = 0;
        while (!bus.out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("drain_started", 32'(bus.out_valid), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_rel_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_rel_valid", 32'(bus.out_valid), 32'd0);
        three_byte_block();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/keccak_unpadder.md
Name: keccak_unpadder

Overview:
- Inverse of the SHA-3 padder. Accepts a stream of padded 32-bit words grouped into rate-sized blocks.
- Strips the trailing SHA-3 pad (0x06 … 0x80, or 0x86 when the pad is a single byte) from the final block.
- Re-emits the original message as 32-bit words, using the padder's own last-word/byte-count convention.
- Used in the loopback path: padded block stream back to UART for self-check of the hashing front end.

Parameters:
RATE_WORDS, 18, block size in 32-bit words (576-bit rate); block bytes NB = 4*RATE_WORDS.
PAD_BYTE, 8'h06, domain/pad-start byte; final pad byte is 8'h80, combined form is PAD_BYTE|8'h80.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_data  in  32  padded word; byte 0 at [31:24] (big-endian within word)
in_valid  in  1  in_data valid
in_last  in  1  word is the final word of the final block
in_ready  out  1  block buffer accepting words
out_data  out  32  message word; unused bytes forced to 0
out_valid  out  1  out_data valid
out_last  out  1  final message word
out_byte_num  out  2  valid bytes in final word (0..3); meaningful only with out_last
out_ready  in  1  downstream accepts word
pad_err  out  1  one-cycle pulse: malformed pad or misplaced in_last; block discarded

Behaviour:
- Reset is synchronous: rst_n low at a clk edge. While in reset, all outputs are 0 (in_ready=0, out_valid=0, out_last=0, out_byte_num=0, out_data=0, pad_err=0). On the first cycle after reset: state FILL, in_ready=1, word index 0.
- Reset mid-operation aborts the current block. No partial output follows.
- Buffer: RATE_WORDS x 32 registers, word index counter, byte scan pointer, message byte count p (0..NB).
- FILL (in_ready=1):
  - Each in_valid&in_ready stores in_data at the word index, then increments the index.
  - Word RATE_WORDS-1 with in_last=0 -> DRAIN_FULL.
  - Word RATE_WORDS-1 with in_last=1 -> SCAN.
  - in_last=1 at any other index -> pad_err pulse, index cleared, stay in FILL.
- SCAN (in_ready=0), one byte per cycle, latency ≤ NB+1 cycles:
  - Byte NB-1 == PAD_BYTE|0x80: p = NB-1, go to DRAIN_LAST.
  - Byte NB-1 == 0x80: walk backward from NB-2. Zero bytes continue the walk. PAD_BYTE gives p = its index, go to DRAIN_LAST. Any other value, or running past byte 0, -> pad_err.
  - Any other final byte -> pad_err.
  - On pad_err: block dropped, return to FILL.
- DRAIN_FULL:
  - Emits all RATE_WORDS words in order with out_last=0, then returns to FILL.
- DRAIN_LAST:
  - Emits floor(p/4) full words with out_last=0.
  - Then one final word with out_last=1 and out_byte_num = p%4. Its bytes at index ≥ p%4 are zeroed.
  - If p%4==0 the final word is 0x00000000 with out_byte_num=0, matching the padder's empty-last-word convention. This includes p=0.
  - Then returns to FILL.
- Output handshake:
  - A word transfers when out_valid&out_ready.
  - While stalled, out_data, out_last and out_byte_num hold stable and out_valid stays high.
  - Outputs are registered. First out_valid comes 1 cycle after entering a DRAIN state. Sustained 1 word/cycle under continuous out_ready.
- in_ready is deasserted throughout SCAN and DRAIN. Input is not overlapped with output.
- pad_err and out_valid are never asserted in the same cycle.

Test Plan:
- 3-byte message: block word0=0x11223306, words1..16=0, word17=0x00000080, in_last on word17 -> single output 0x11223300, out_last=1, out_byte_num=3.
- Empty message: word0=0x06000000, word17=0x00000080 -> one word 0x00000000, out_last=1, out_byte_num=0.
- 71-byte message: final byte 0x86 -> 17 words out_last=0, then last word with 3 bytes, out_byte_num=3, low byte 0.
- 72-byte message over two blocks: block 1 data (in_last=0), block 2 = 0x06000000, 0…, 0x00000080 -> 18 words unchanged with out_last=0, then 0x00000000 out_last=1 out_byte_num=0.
- Errors:
  - word17=0x00000000 -> pad_err pulse, no out_valid, in_ready=1 next cycle.
  - in_last on word 5 -> pad_err, index reset.
  - Data byte 0x11 between 0x06 and 0x80 -> pad_err.
- Stall and reset:
  - Random out_ready during DRAIN -> data stable while stalled, no word lost or duplicated.
  - rst_n low mid-DRAIN -> out_valid=0 next cycle, in_ready=1 the cycle after rst_n rises, next block decodes cleanly.
